// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage pipeline sequencer.
package pipe_pkg;
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } seq_state_e;

   localparam logic [5:0] OP_HALT  = 6'b111111;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_sequencer_hazard_detect.sv
// Load-use comparator: EX load whose destination is read by the ID instruction.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_memrd,
   input  logic [4:0] ex_dst,
   output logic       hazard
);
   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = id_use_rs && (id_rs == ex_dst);
   assign w_rt_match = id_use_rt && (id_rt == ex_dst);
   // r0 is hardwired, so a load "to" r0 never produces a value worth waiting for
   assign hazard     = ex_memrd && (ex_dst != REG_ZERO) && (w_rs_match || w_rt_match);
endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: load-use stalls, branch/jump squash, halt drain/freeze.
//
// state  | meaning
// RUN    | normal issue; hazards, branches, jumps and halt handled here
// DRAIN  | halt left ID; bubbles only while EX/MEM/WB empty out
// HALTED | pipeline frozen until reset
module pipe_sequencer
   import pipe_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_halt,
   input  logic             id_jump,
   input  logic             ex_memrd,
   input  logic [4:0]       ex_dst,
   input  logic             ex_br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   seq_state_e       r_state, w_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic             r_halted;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_hazard, w_stall_inc, w_flush_inc;

   hazard_detect u_hazard (
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .ex_memrd  (ex_memrd),
      .ex_dst    (ex_dst),
      .hazard    (w_hazard)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_cnt       <= '0;
         r_halted    <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt_next;
         r_halted <= (w_next == HALTED);
         if (w_stall_inc && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_inc && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_cnt_next  = r_cnt;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      case (r_state)
         RUN: begin
            // a taken branch outranks everything: ID contents are wrong-path
            if (ex_br_taken) begin
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               w_flush_inc = 1'b1;
            end else if (w_hazard) begin
               idex_flush  = 1'b1;
               w_stall_inc = 1'b1;
            end else if (id_halt) begin
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               w_next      = DRAIN;
               w_cnt_next  = CW'(DRAIN_CYCLES - 1);
            end else if (id_jump) begin
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               w_flush_inc = 1'b1;
            end else begin
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
            end
         end
         DRAIN: begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (r_cnt == '0) w_next = HALTED;
            else             w_cnt_next = r_cnt - 1'b1;
         end
         HALTED: ;
         default: w_next = RUN;
      endcase
      if (rst) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end
   end

   assign halted    = r_halted && !rst;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: cycle model plus directed literal checks.
module tb_pipe_sequencer;
   localparam int DRAIN_CYCLES = 3;
   localparam int CNT_W        = 16;
   localparam int MAXC         = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_dst = '0;
   logic id_use_rs = 0, id_use_rt = 0, id_halt = 0, id_jump = 0, ex_memrd = 0, ex_br_taken = 0;
   logic pc_en, ifid_en, ifid_flush, idex_flush, halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // model: halt acceptance is stamped with a cycle number; phase derives from elapsed cycles
   int m_cyc     = 0;
   int m_halt_at = -1;
   int m_stall   = 0;
   int m_flush   = 0;

   pipe_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_halt(id_halt), .id_jump(id_jump), .ex_memrd(ex_memrd), .ex_dst(ex_dst),
      .ex_br_taken(ex_br_taken),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   // compare process: inputs settle at negedge, check 3 ns later, then advance model
   always @(negedge clk) begin
      int  d, phase;
      logic hz;
      logic [3:0] e;
      #3;
      hz = ex_memrd && (ex_dst != 0) &&
           ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
      d  = (m_halt_at < 0) ? 0 : m_cyc - m_halt_at;
      phase = (m_halt_at < 0 || d == 0) ? 0 : (d <= DRAIN_CYCLES) ? 1 : 2;
      if (rst)               e = 4'b0011;
      else if (phase == 1)   e = 4'b0111;
      else if (phase == 2)   e = 4'b0000;
      else if (ex_br_taken)  e = 4'b1111;
      else if (hz)           e = 4'b0001;
      else if (id_halt)      e = 4'b0110;
      else if (id_jump)      e = 4'b1110;
      else                   e = 4'b1100;
      chk("pc_en",      {31'd0, pc_en},      {31'd0, e[3]});
      chk("ifid_en",    {31'd0, ifid_en},    {31'd0, e[2]});
      chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e[1]});
      chk("idex_flush", {31'd0, idex_flush}, {31'd0, e[0]});
      chk("halted",     {31'd0, halted},     {31'd0, (!rst && phase == 2)});
      chk("stall_cnt",  {16'd0, stall_cnt},  rst ? 32'd0 : sat(m_stall));
      chk("flush_cnt",  {16'd0, flush_cnt},  rst ? 32'd0 : sat(m_flush));
      if (rst) begin
         m_halt_at = -1; m_stall = 0; m_flush = 0;
      end else if (phase == 0) begin
         if (ex_br_taken)  m_flush++;
         else if (hz)      m_stall++;
         else if (id_halt) m_halt_at = m_cyc;
         else if (id_jump) m_flush++;
      end
      m_cyc++;
   end

   task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic hlt, input logic jmp,
                        input logic mrd, input logic [4:0] dst, input logic br);
      @(negedge clk);
      rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_halt = hlt; id_jump = jmp; ex_memrd = mrd; ex_dst = dst; ex_br_taken = br;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drive_rand();
      drive(0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(); #3;
      chk("lit_reset_pc_en", {31'd0, pc_en}, 1);
      chk("lit_reset_ifid_en", {31'd0, ifid_en}, 1);
      chk("lit_reset_stall", {16'd0, stall_cnt}, 0);
      chk("lit_reset_halted", {31'd0, halted}, 0);

      drive(0, 8, 0, 1, 0, 0, 0, 1, 8, 0); #3;
      chk("lit_lu_pc_en", {31'd0, pc_en}, 0);
      chk("lit_lu_ifid_en", {31'd0, ifid_en}, 0);
      chk("lit_lu_idex_flush", {31'd0, idex_flush}, 1);
      idle(); #3;
      chk("lit_lu_stall_cnt", {16'd0, stall_cnt}, 1);

      drive(0, 0, 0, 1, 0, 0, 0, 1, 0, 0); #3;
      chk("lit_r0_pc_en", {31'd0, pc_en}, 1);
      drive(0, 0, 9, 0, 1, 0, 0, 1, 9, 0);   // rt match stalls
      drive(0, 9, 0, 0, 0, 0, 0, 1, 9, 0);   // rs match but not read: no stall
      idle(); #3;
      chk("lit_rt_stall_cnt", {16'd0, stall_cnt}, 2);

      drive(0, 7, 0, 1, 0, 1, 0, 1, 7, 1); #3;
      chk("lit_br_pc_en", {31'd0, pc_en}, 1);
      chk("lit_br_ifid_flush", {31'd0, ifid_flush}, 1);
      chk("lit_br_idex_flush", {31'd0, idex_flush}, 1);
      idle(); #3;
      chk("lit_br_flush_cnt", {16'd0, flush_cnt}, 1);
      chk("lit_br_still_run", {31'd0, pc_en}, 1);

      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); #3;
      chk("lit_j_ifid_flush", {31'd0, ifid_flush}, 1);
      chk("lit_j_idex_flush", {31'd0, idex_flush}, 0);
      chk("lit_j_pc_en", {31'd0, pc_en}, 1);
      idle(); #3;
      chk("lit_j_flush_cnt", {16'd0, flush_cnt}, 2);

      for (int i = 0; i < (1 << CNT_W) + 3; i++) drive(0, 3, 0, 1, 0, 0, 0, 1, 3, 0);
      idle(); #3;
      chk("lit_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #3;
      chk("lit_halt_pc_en", {31'd0, pc_en}, 0);
      for (int i = 1; i <= 3; i++) drive_rand();
      #3 chk("lit_halt_n3", {31'd0, halted}, 0);
      drive_rand(); #3;
      chk("lit_halt_n4", {31'd0, halted}, 1);
      for (int i = 0; i < 10; i++) begin
         drive_rand(); #3;
         chk("lit_halt_hold", {31'd0, halted}, 1);
      end

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // halt at N
      drive_rand();                           // N+1
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #3; // reset at N+2
      chk("lit_rst_pc_en", {31'd0, pc_en}, 0);
      chk("lit_rst_ifid_flush", {31'd0, ifid_flush}, 1);
      chk("lit_rst_idex_flush", {31'd0, idex_flush}, 1);
      chk("lit_rst_stall", {16'd0, stall_cnt}, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(); #3;
      chk("lit_rst_back_run", {31'd0, pc_en}, 1);
      chk("lit_rst_halted", {31'd0, halted}, 0);
      for (int i = 0; i < 6; i++) idle();
      #3 chk("lit_rst_stays_run", {31'd0, halted}, 0);

      @(negedge clk); #5;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Central pipeline sequencer for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Consumes ID-stage decode flags and EX-stage status, and drives PC enable, IF/ID enable and flush, and ID/EX flush.
- Detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and sequences halt: stop fetch, drain in-flight instructions, then freeze.
- Keeps saturating stall and flush performance counters.

Parameters:
- DRAIN_CYCLES, 3, cycles after halt leaves ID before the pipeline counts as drained (EX, MEM, WB).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_halt  in  1  ID opcode is 6'b111111
- id_jump  in  1  ID is j, jal or jr (target resolved in ID)
- ex_memrd  in  1  instruction in EX is a load (lw, lhu)
- ex_dst  in  5  destination register of the EX instruction
- ex_br_taken  in  1  branch (beq/bne/bltz) resolved taken in EX
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  load a bubble into IF/ID
- idex_flush  out  1  load a bubble into ID/EX
- halted  out  1  pipeline drained and frozen
- stall_cnt  out  CNT_W  cycles spent in load-use stall
- flush_cnt  out  CNT_W  flush events (branch or jump)

Behaviour:
- Reset: while rst=1, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, halted=0. Asynchronously, state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0. Normal operation starts on the first rising edge after rst falls.
- States: RUN, DRAIN, HALTED. Outputs are combinational from state and inputs, except halted, which is registered.
- RUN, in priority order, first match wins:
  1. ex_br_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. flush_cnt+1. Any id_halt or id_jump in the same cycle is wrong-path and ignored.
  2. Load-use: ex_memrd and ex_dst!=0 and ((id_use_rs and id_rs==ex_dst) or (id_use_rt and id_rt==ex_dst)). pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1. stall_cnt+1. Exactly one bubble per hazard.
  3. id_halt=1: pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=0 (halt proceeds to EX). Next state DRAIN, counter=DRAIN_CYCLES-1.
  4. id_jump=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0. flush_cnt+1.
  5. Otherwise: pc_en=1, ifid_en=1, both flushes 0.
- DRAIN: pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=1. All ID and EX inputs are ignored, since only bubbles follow the halt. Counter decrements each cycle. At counter==0 the next state is HALTED.
- HALTED: pc_en=0, ifid_en=0, both flushes 0, halted=1 from the first HALTED cycle. Only rst leaves this state.
- Counters saturate at all-ones; they do not wrap.
- Register 0 never creates a load-use hazard.
- Reset asserted mid-DRAIN or in HALTED returns to RUN with counters cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
  - OP_HALT=6'b111111
  - REG_ZERO=5'd0
- One natural sub-module: hazard_detect, a purely combinational load-use comparator (id_rs, id_rt, use flags, ex_memrd, ex_dst -> hazard).

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> pc_en=1, ifid_en=1, counters=0, halted=0 on the first cycle after release.
- Load-use: ex_memrd=1, ex_dst=5'd8, id_rs=5'd8, id_use_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle, stall_cnt=1. Same stimulus with ex_dst=0 -> no stall.
- Branch vs hazard: ex_br_taken=1 together with a load-use match and id_halt=1 -> ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, state stays RUN.
- Jump: id_jump=1 for one cycle -> ifid_flush=1, idex_flush=0, pc_en=1, flush_cnt increments by 1.
- Halt: id_halt=1 at cycle N -> pc_en=0 from N, halted=1 at cycle N+4 (DRAIN N+1..N+3), and it stays 1 for 10 further cycles under random inputs.
- Reset mid-DRAIN: assert rst at N+2 -> outputs take their reset values immediately, and after release the block returns to RUN with halted=0; counter saturation is checked by forcing 2^CNT_W+3 stalls -> stall_cnt=16'hFFFF.
